// File: rtl/enemy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : enemy_pkg
//  Description : Shared state encoding, counter widths and in-flight bullet
//                bookkeeping helper for the enemy fire scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package enemy_pkg;

    // Frame cooldown counter width (cooldown range 1..255)
    localparam int c_cnt_w      = 8;
    // In-flight bullet counter width (limit range 1..7)
    localparam int c_inflight_w = 3;

    // Scheduler states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        COOLDOWN = 2'd0,
        ARB      = 2'd1,
        GRANT    = 2'd2
    } fire_state_e;

    // Next bullet count: a launch and a retirement in the same cycle cancel,
    // otherwise step up (clamped at the limit) or down (clamped at zero).
    function automatic logic [c_inflight_w-1:0] next_in_flight(
        input logic [c_inflight_w-1:0] cur,
        input logic [c_inflight_w-1:0] limit,
        input logic                    launch,
        input logic                    retire
    );
        logic [c_inflight_w-1:0] res;
        res = cur;
        if (launch && !retire) begin
            if (cur < limit) begin
                res = cur + 1'b1;
            end
        end else if (retire && !launch) begin
            if (cur != '0) begin
                res = cur - 1'b1;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Returns the first set
//                request strictly after last_idx, wrapping at NUM_REQ-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import enemy_pkg::*;
#(
    parameter int NUM_REQ = 10,
    parameter int IDX_W   = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               valid
);

    logic [IDX_W-1:0] w_cand;

    // Scan candidates in rotation order starting one past the last winner
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        w_cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(last_idx) + k) % NUM_REQ);
            if (!valid && req[w_cand]) begin
                valid         = 1'b1;
                grant[w_cand] = 1'b1;
                grant_idx     = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/enemy_fire_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : enemy_fire_scheduler
//  Description : Decides which enemy column may shoot next. Waits a number
//                of video frames between shots, limits bullets on screen and
//                rotates fairly across columns with living shooters.
//  Revision    : 1.0 - initial release
// ============================================================================
module enemy_fire_scheduler
    import enemy_pkg::*;
#(
    parameter int num_columns_p     = 10,
    parameter int cooldown_frames_p = 8,
    parameter int max_bullets_p     = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     enable_i,
    input  logic                     frame_i,
    input  logic [num_columns_p-1:0] req_i,
    input  logic                     fire_ack_i,
    input  logic                     bullet_done_i,
    output logic [num_columns_p-1:0] grant_o,
    output logic                     grant_valid_o,
    output logic [2:0]               in_flight_o
);

    localparam int                      c_idx_w    = (num_columns_p > 1) ? $clog2(num_columns_p) : 1;
    localparam logic [c_idx_w-1:0]      c_last_rst = c_idx_w'(num_columns_p - 1);
    localparam logic [c_cnt_w-1:0]      c_reload   = c_cnt_w'(cooldown_frames_p);
    localparam logic [c_inflight_w-1:0] c_max      = c_inflight_w'(max_bullets_p);

    fire_state_e               r_state;
    logic [c_cnt_w-1:0]        r_count;
    logic [c_inflight_w-1:0]   r_in_flight;
    logic [num_columns_p-1:0]  r_grant;
    logic                      r_grant_valid;
    logic [c_idx_w-1:0]        r_last;
    logic [c_idx_w-1:0]        r_winner;

    logic [num_columns_p-1:0]  w_arb_grant;
    logic [c_idx_w-1:0]        w_arb_idx;
    logic                      w_arb_valid;
    logic                      w_launch;
    logic                      w_winner_alive;
    logic                      w_can_fire;

    rr_arbiter #(
        .NUM_REQ (num_columns_p),
        .IDX_W   (c_idx_w)
    ) u_rr_arbiter (
        .req       (req_i),
        .last_idx  (r_last),
        .grant     (w_arb_grant),
        .grant_idx (w_arb_idx),
        .valid     (w_arb_valid)
    );

    // An ack only counts while a grant is live and the game is running
    assign w_launch       = enable_i && (r_state == GRANT) && fire_ack_i;
    assign w_winner_alive = req_i[r_winner];
    assign w_can_fire     = w_arb_valid && (r_in_flight < c_max);

    // Cooldown / arbitration / grant sequencing and registered grant outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state       <= COOLDOWN;
            r_count       <= c_reload;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_last        <= c_last_rst;
            r_winner      <= '0;
        end else if (!enable_i) begin
            // Game paused: drop any grant and restart the full cooldown
            r_state       <= COOLDOWN;
            r_count       <= c_reload;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
        end else begin
            case (r_state)
                COOLDOWN: begin
                    if (frame_i) begin
                        if (r_count == 8'd1) begin
                            r_state <= ARB;
                        end else begin
                            r_count <= r_count - 1'b1;
                        end
                    end
                end
                ARB: begin
                    if (w_can_fire) begin
                        r_grant       <= w_arb_grant;
                        r_grant_valid <= 1'b1;
                        r_winner      <= w_arb_idx;
                        r_state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (fire_ack_i) begin
                        // Shot fired: winner becomes the rotation point
                        r_grant       <= '0;
                        r_grant_valid <= 1'b0;
                        r_last        <= r_winner;
                        r_count       <= c_reload;
                        r_state       <= COOLDOWN;
                    end else if (!w_winner_alive) begin
                        // Shooter died before firing: re-arbitrate at once
                        r_grant       <= '0;
                        r_grant_valid <= 1'b0;
                        r_state       <= ARB;
                    end
                end
                default: begin
                    r_state       <= COOLDOWN;
                    r_count       <= c_reload;
                    r_grant       <= '0;
                    r_grant_valid <= 1'b0;
                end
            endcase
        end
    end

    // Bullet-on-screen count, tracked regardless of enable
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_in_flight <= '0;
        end else begin
            r_in_flight <= next_in_flight(r_in_flight, c_max, w_launch, bullet_done_i);
        end
    end

    assign grant_o       = r_grant;
    assign grant_valid_o = r_grant_valid;
    assign in_flight_o   = r_in_flight;

endmodule
`default_nettype wire

// File: tb/tb_enemy_fire_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_enemy_fire_scheduler
//  Description : Self-checking bench for enemy_fire_scheduler: directed
//                vector table, hand-written corner sequences and a random
//                run compared against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_enemy_fire_scheduler;

    localparam int NC = 10;
    localparam int CD = 8;
    localparam int MB = 2;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          enable_i;
    logic          frame_i;
    logic [NC-1:0] req_i;
    logic          fire_ack_i;
    logic          bullet_done_i;
    logic [NC-1:0] grant_o;
    logic          grant_valid_o;
    logic [2:0]    in_flight_o;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int m_holder;   // column currently holding the grant, -1 for none
    int m_frames;   // frames still to wait before a shot may be offered
    int m_last;     // column that fired most recently
    int m_bullets;  // bullets on screen

    typedef struct {
        logic          en;
        logic          fr;
        logic [NC-1:0] rq;
        logic          ak;
        logic          dn;
        logic [NC-1:0] g;
        logic          v;
        logic [2:0]    f;
    } vec_t;

    vec_t tbl [11];

    enemy_fire_scheduler #(
        .num_columns_p     (NC),
        .cooldown_frames_p (CD),
        .max_bullets_p     (MB)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .enable_i      (enable_i),
        .frame_i       (frame_i),
        .req_i         (req_i),
        .fire_ack_i    (fire_ack_i),
        .bullet_done_i (bullet_done_i),
        .grant_o       (grant_o),
        .grant_valid_o (grant_valid_o),
        .in_flight_o   (in_flight_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NC-1:0] r, input int last);
        for (int k = 1; k <= NC; k++) begin
            int c;
            c = (last + k) % NC;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_holder  = -1;
        m_frames  = CD;
        m_last    = NC - 1;
        m_bullets = 0;
    endtask

    task automatic model_step(input logic en, input logic fr, input logic [NC-1:0] rq,
                              input logic ak, input logic dn);
        bit shot;
        int b0;
        shot = en && (m_holder >= 0) && ak;
        b0   = m_bullets;
        if (!en) begin
            m_holder = -1;
            m_frames = CD;
        end else if (m_holder >= 0) begin
            if (ak) begin
                m_last   = m_holder;
                m_holder = -1;
                m_frames = CD;
            end else if (!rq[m_holder]) begin
                m_holder = -1;
            end
        end else if (m_frames > 0) begin
            if (fr) m_frames = m_frames - 1;
        end else if (b0 < MB) begin
            m_holder = rr_pick(rq, m_last);
        end
        if (shot && !dn) begin
            if (b0 < MB) m_bullets = b0 + 1;
        end else if (dn && !shot) begin
            if (b0 > 0) m_bullets = b0 - 1;
        end
    endtask

    function automatic logic [NC-1:0] model_grant();
        logic [NC-1:0] g;
        g = '0;
        if (m_holder >= 0) g[m_holder] = 1'b1;
        return g;
    endfunction

    // Apply one cycle of inputs, advance the model on the edge, settle 1 unit
    task automatic step(input logic en, input logic fr, input logic [NC-1:0] rq,
                        input logic ak, input logic dn);
        enable_i      = en;
        frame_i       = fr;
        req_i         = rq;
        fire_ack_i    = ak;
        bullet_done_i = dn;
        @(posedge clk);
        model_step(en, fr, rq, ak, dn);
        #1;
    endtask

    task automatic frames(input int n, input logic [NC-1:0] rq);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, rq, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset_i       = 1'b1;
        enable_i      = 1'b0;
        frame_i       = 1'b0;
        req_i         = '0;
        fire_ack_i    = 1'b0;
        bullet_done_i = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, 1'b1, 10'h3FF, 1'b0, 1'b0, 10'h000, 1'b0, 3'd0};
        tbl[8]  = '{1'b1, 1'b0, 10'h3FF, 1'b0, 1'b0, 10'h001, 1'b1, 3'd0};
        tbl[9]  = '{1'b1, 1'b0, 10'h3FF, 1'b1, 1'b0, 10'h000, 1'b0, 3'd1};
        tbl[10] = '{1'b1, 1'b0, 10'h3FF, 1'b0, 1'b1, 10'h000, 1'b0, 3'd0};

        // Reset state
        do_reset();
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_valid", 32'(grant_valid_o), 32'h0);
        chk("rst_inflight", 32'(in_flight_o), 32'h0);

        // First grant after the full cooldown, then ack and retire
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].en, tbl[i].fr, tbl[i].rq, tbl[i].ak, tbl[i].dn);
            chk($sformatf("vec%0d_grant", i), 32'(grant_o), 32'(tbl[i].g));
            chk($sformatf("vec%0d_valid", i), 32'(grant_valid_o), 32'(tbl[i].v));
            chk($sformatf("vec%0d_inflight", i), 32'(in_flight_o), 32'(tbl[i].f));
        end

        // Round-robin through every column and wrap back to column 0
        for (int i = 1; i <= NC; i++) begin
            logic [NC-1:0] e;
            e = '0;
            e[i % NC] = 1'b1;
            frames(CD, 10'h3FF);
            step(1'b1, 1'b0, 10'h3FF, 1'b0, 1'b0);
            chk($sformatf("rr%0d_grant", i), 32'(grant_o), 32'(e));
            step(1'b1, 1'b0, 10'h3FF, 1'b1, 1'b0);
            step(1'b1, 1'b0, 10'h3FF, 1'b0, 1'b1);
        end

        // Bullet limit stalls arbitration until a bullet retires
        do_reset();
        frames(CD, 10'h3FF);
        step(1'b1, 1'b0, 10'h3FF, 1'b0, 1'b0);
        chk("lim_g0", 32'(grant_o), 32'h001);
        step(1'b1, 1'b0, 10'h3FF, 1'b1, 1'b0);
        frames(CD, 10'h3FF);
        step(1'b1, 1'b0, 10'h3FF, 1'b0, 1'b0);
        chk("lim_g1", 32'(grant_o), 32'h002);
        step(1'b1, 1'b0, 10'h3FF, 1'b1, 1'b0);
        chk("lim_inflight2", 32'(in_flight_o), 32'd2);
        frames(CD, 10'h3FF);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 10'h3FF, 1'b0, 1'b0);
        chk("lim_hold_valid", 32'(grant_valid_o), 32'h0);
        chk("lim_hold_grant", 32'(grant_o), 32'h0);
        step(1'b1, 1'b0, 10'h3FF, 1'b0, 1'b1);
        chk("lim_done_inflight", 32'(in_flight_o), 32'd1);
        chk("lim_done_valid", 32'(grant_valid_o), 32'h0);
        step(1'b1, 1'b0, 10'h3FF, 1'b0, 1'b0);
        chk("lim_release_grant", 32'(grant_o), 32'h004);
        chk("lim_release_valid", 32'(grant_valid_o), 32'h1);

        // Granted column dies: re-arbitrate without cooldown
        do_reset();
        frames(CD, 10'h008);
        step(1'b1, 1'b0, 10'h008, 1'b0, 1'b0);
        chk("die_g3", 32'(grant_o), 32'h008);
        step(1'b1, 1'b0, 10'h080, 1'b0, 1'b0);
        chk("die_withdrawn", 32'(grant_o), 32'h000);
        step(1'b1, 1'b0, 10'h080, 1'b0, 1'b0);
        chk("die_g7", 32'(grant_o), 32'h080);
        chk("die_inflight", 32'(in_flight_o), 32'd0);

        // Simultaneous ack and done at one bullet, then done at zero
        step(1'b1, 1'b0, 10'h080, 1'b1, 1'b0);
        chk("sim_inflight1", 32'(in_flight_o), 32'd1);
        frames(CD, 10'h3FF);
        step(1'b1, 1'b0, 10'h3FF, 1'b0, 1'b0);
        chk("sim_g8", 32'(grant_o), 32'h100);
        step(1'b1, 1'b0, 10'h3FF, 1'b1, 1'b1);
        chk("sim_ackdone_inflight", 32'(in_flight_o), 32'd1);
        chk("sim_ackdone_grant", 32'(grant_o), 32'h000);
        step(1'b1, 1'b0, 10'h3FF, 1'b0, 1'b1);
        chk("sim_done_inflight", 32'(in_flight_o), 32'd0);
        step(1'b1, 1'b0, 10'h3FF, 1'b0, 1'b1);
        chk("sim_done_at_zero", 32'(in_flight_o), 32'd0);

        // Asynchronous reset in the middle of a grant
        do_reset();
        frames(CD, 10'h3FF);
        step(1'b1, 1'b0, 10'h3FF, 1'b0, 1'b0);
        chk("ar_pre_grant", 32'(grant_o), 32'h001);
        #2;
        reset_i = 1'b1;
        #1;
        chk("ar_grant", 32'(grant_o), 32'h000);
        chk("ar_valid", 32'(grant_valid_o), 32'h0);
        chk("ar_inflight", 32'(in_flight_o), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset_i = 1'b0;

        // Enable drop mid-cooldown restarts the whole frame count
        frames(4, 10'h3FF);
        step(1'b0, 1'b0, 10'h3FF, 1'b0, 1'b0);
        frames(CD - 1, 10'h3FF);
        step(1'b1, 1'b0, 10'h3FF, 1'b0, 1'b0);
        chk("en_reload_nogrant", 32'(grant_valid_o), 32'h0);
        frames(1, 10'h3FF);
        step(1'b1, 1'b0, 10'h3FF, 1'b0, 1'b0);
        chk("en_reload_grant", 32'(grant_o), 32'h001);

        // Random run against the behavioural model
        do_reset();
        begin
            logic [NC-1:0] rq;
            rq = '1;
            for (int i = 0; i < 3000; i++) begin
                logic en, fr, ak, dn;
                if ($urandom_range(0, 7) == 0) begin
                    case ($urandom_range(0, 3))
                        0:       rq = '1;
                        1:       rq = NC'($urandom);
                        2:       rq = NC'(1) << $urandom_range(0, NC - 1);
                        default: rq = NC'($urandom) & NC'($urandom);
                    endcase
                end
                en = ($urandom_range(0, 39) != 0);
                fr = ($urandom_range(0, 2) == 0);
                ak = (m_holder >= 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
                dn = ($urandom_range(0, 5) == 0);
                step(en, fr, rq, ak, dn);
                chk("rand_grant", 32'(grant_o), 32'(model_grant()));
                chk("rand_valid", 32'(grant_valid_o), 32'(m_holder >= 0));
                chk("rand_inflight", 32'(in_flight_o), 32'(m_bullets));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
